// File: rtl/pc_sequencer_if.sv
// Fetch-control bus between the core pipeline controls and the PC sequencer.
// The sequencer takes the slave side; the pipeline (or bench) drives the master side.
interface pc_sequencer_if #(
  parameter int unsigned PC_W = 9
);
  logic            PcSel;
  logic [31:0]     BrPC;
  logic            Stall;
  logic            Halt;
  logic            Resume;
  logic [PC_W-1:0] PC;
  logic            FetchValid;
  logic            Flush_IF_ID;
  logic            Flush_ID_EX;
  logic            Halted;
  logic            Fault;
  logic [15:0]     BrCount;

  modport master (
    output PcSel, BrPC, Stall, Halt, Resume,
    input  PC, FetchValid, Flush_IF_ID, Flush_ID_EX, Halted, Fault, BrCount
  );

  modport slave (
    input  PcSel, BrPC, Stall, Halt, Resume,
    output PC, FetchValid, Flush_IF_ID, Flush_ID_EX, Halted, Fault, BrCount
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the fetch PC, arbitrates redirect/halt/stall/sequential,
// raises pipeline flushes, traps illegal branch targets and counts taken redirects.
module pc_sequencer #(
  parameter int unsigned PC_W = 9
) (
  input  logic          clk,
  input  logic          reset,
  pc_sequencer_if.slave bus
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned ST_W  = 2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [ST_W-1:0] ST_RUN    = 2'd0;
  localparam logic [ST_W-1:0] ST_HALTED = 2'd1;
  localparam logic [ST_W-1:0] ST_FAULT  = 2'd2;

  logic [ST_W-1:0]  state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fv_q, fv_d;
  logic             halted_q, halted_d;
  logic             fault_q, fault_d;
  logic             flush_ifid, flush_idex;
  logic             tgt_legal;

  // Target must be word aligned and lie inside the 2^PC_W byte instruction memory.
  assign tgt_legal = (bus.BrPC[1:0] == 2'b00) && ((bus.BrPC >> PC_W) == 32'd0);

  // Next-state, next-PC, counter and flush decode.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (bus.PcSel) begin
          flush_ifid = 1'b1;
          flush_idex = 1'b1;
          if (tgt_legal) begin
            pc_d = bus.BrPC[PC_W-1:0];
            if (cnt_q != CNT_MAX) begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            state_d = ST_FAULT;
          end
        end else if (bus.Halt) begin
          // Only the fetched successor is dropped; the halt itself proceeds to EX.
          state_d    = ST_HALTED;
          flush_ifid = 1'b1;
        end else if (!bus.Stall) begin
          pc_d = pc_q + PC_W'(4);
        end
      end
      ST_HALTED: begin
        if (bus.Resume) begin
          state_d = ST_RUN;
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_FAULT;
      end
    endcase

    // Fetch is live only once a full cycle has been spent in RUN.
    fv_d     = (state_q == ST_RUN) && (state_d == ST_RUN);
    halted_d = (state_d == ST_HALTED);
    fault_d  = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_RUN;
      pc_q     <= '0;
      cnt_q    <= '0;
      fv_q     <= 1'b0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      fv_q     <= fv_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
    end
  end

  // Flushes are combinational but must read 0 while reset is held.
  assign bus.Flush_IF_ID = reset & flush_ifid;
  assign bus.Flush_ID_EX = reset & flush_idex;
  assign bus.PC          = pc_q;
  assign bus.FetchValid  = fv_q;
  assign bus.Halted      = halted_q;
  assign bus.Fault       = fault_q;
  assign bus.BrCount     = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: post-edge expectations go through a scoreboard queue,
// combinational flush strobes are checked in-cycle.
module tb_pc_sequencer;

  localparam int unsigned PC_W = 9;

  localparam int SEL_PC  = 0;
  localparam int SEL_FV  = 1;
  localparam int SEL_HLT = 2;
  localparam int SEL_FLT = 3;
  localparam int SEL_CNT = 4;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  exp_t sb[$];

  pc_sequencer_if #(.PC_W(PC_W)) bus ();

  pc_sequencer #(.PC_W(PC_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      SEL_PC:  return 32'(bus.PC);
      SEL_FV:  return 32'(bus.FetchValid);
      SEL_HLT: return 32'(bus.Halted);
      SEL_FLT: return 32'(bus.Fault);
      SEL_CNT: return 32'(bus.BrCount);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, observe(e.sel), e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic flushes(input string tag, input logic exp_if, input logic exp_ex);
    #1;
    check({tag, "_flush_if_id"}, 32'(bus.Flush_IF_ID), 32'(exp_if));
    check({tag, "_flush_id_ex"}, 32'(bus.Flush_ID_EX), 32'(exp_ex));
  endtask

  task automatic idle_inputs();
    bus.PcSel  = 1'b0;
    bus.BrPC   = 32'h0;
    bus.Stall  = 1'b0;
    bus.Halt   = 1'b0;
    bus.Resume = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    idle_inputs();

    // Reset values, with a redirect request held during reset.
    reset     = 1'b0;
    bus.PcSel = 1'b1;
    bus.BrPC  = 32'h40;
    push("rst_pc", SEL_PC, 32'h0);
    push("rst_fv", SEL_FV, 32'h0);
    push("rst_halted", SEL_HLT, 32'h0);
    push("rst_fault", SEL_FLT, 32'h0);
    push("rst_brcount", SEL_CNT, 32'h0);
    flushes("rst", 1'b0, 1'b0);
    drain();
    idle_inputs();
    @(negedge clk);
    reset = 1'b1;

    // Sequential fetch from 0.
    for (int i = 1; i <= 4; i++) begin
      flushes("seq", 1'b0, 1'b0);
      push("seq_pc", SEL_PC, 32'(4 * i));
      push("seq_fv", SEL_FV, 32'h1);
      tick();
    end

    // Redirect at PC=0x010 with a simultaneous stall.
    bus.PcSel = 1'b1;
    bus.BrPC  = 32'h40;
    bus.Stall = 1'b1;
    flushes("br_stall", 1'b1, 1'b1);
    push("br_stall_pc", SEL_PC, 32'h40);
    push("br_stall_cnt", SEL_CNT, 32'h1);
    push("br_stall_fv", SEL_FV, 32'h1);
    tick();
    idle_inputs();

    // Redirect beats a simultaneous halt; lands on the last word.
    bus.PcSel = 1'b1;
    bus.BrPC  = 32'h1FC;
    bus.Halt  = 1'b1;
    flushes("br_halt", 1'b1, 1'b1);
    push("br_halt_pc", SEL_PC, 32'h1FC);
    push("br_halt_halted", SEL_HLT, 32'h0);
    push("br_halt_cnt", SEL_CNT, 32'h2);
    tick();
    idle_inputs();

    push("wrap_pc", SEL_PC, 32'h000);
    tick();

    bus.PcSel = 1'b1;
    bus.BrPC  = 32'h20;
    push("br20_pc", SEL_PC, 32'h20);
    push("br20_cnt", SEL_CNT, 32'h3);
    tick();
    idle_inputs();

    // Halt with stall at PC=0x020.
    bus.Halt  = 1'b1;
    bus.Stall = 1'b1;
    flushes("halt", 1'b1, 1'b0);
    push("halt_halted", SEL_HLT, 32'h1);
    push("halt_fv", SEL_FV, 32'h0);
    push("halt_pc", SEL_PC, 32'h20);
    tick();
    idle_inputs();

    // HALTED ignores redirect/halt/stall for 10 cycles.
    bus.PcSel = 1'b1;
    bus.BrPC  = 32'h80;
    bus.Halt  = 1'b1;
    bus.Stall = 1'b1;
    for (int i = 0; i < 10; i++) begin
      flushes("halted_hold", 1'b0, 1'b0);
      push("halted_hold_pc", SEL_PC, 32'h20);
      push("halted_hold_halted", SEL_HLT, 32'h1);
      push("halted_hold_cnt", SEL_CNT, 32'h3);
      tick();
    end
    idle_inputs();

    bus.Resume = 1'b1;
    push("resume_halted", SEL_HLT, 32'h0);
    push("resume_fv", SEL_FV, 32'h0);
    push("resume_pc", SEL_PC, 32'h20);
    tick();
    idle_inputs();
    push("after_resume_pc", SEL_PC, 32'h24);
    push("after_resume_fv", SEL_FV, 32'h1);
    tick();

    // Resume in RUN has no effect.
    bus.Resume = 1'b1;
    push("resume_run_pc", SEL_PC, 32'h28);
    push("resume_run_halted", SEL_HLT, 32'h0);
    tick();
    idle_inputs();

    // Misaligned target traps.
    bus.PcSel = 1'b1;
    bus.BrPC  = 32'h42;
    flushes("fault_mis", 1'b1, 1'b1);
    push("fault_mis_fault", SEL_FLT, 32'h1);
    push("fault_mis_pc", SEL_PC, 32'h28);
    push("fault_mis_cnt", SEL_CNT, 32'h3);
    push("fault_mis_fv", SEL_FV, 32'h0);
    tick();
    bus.BrPC   = 32'h40;
    bus.Halt   = 1'b1;
    bus.Resume = 1'b1;
    flushes("fault_hold", 1'b0, 1'b0);
    push("fault_hold_fault", SEL_FLT, 32'h1);
    push("fault_hold_pc", SEL_PC, 32'h28);
    push("fault_hold_cnt", SEL_CNT, 32'h3);
    push("fault_hold_halted", SEL_HLT, 32'h0);
    tick();
    idle_inputs();

    reset = 1'b0;
    #1;
    push("fault_rst_fault", SEL_FLT, 32'h0);
    push("fault_rst_pc", SEL_PC, 32'h0);
    push("fault_rst_cnt", SEL_CNT, 32'h0);
    drain();
    @(negedge clk);
    reset = 1'b1;

    // Out-of-range target traps.
    bus.PcSel = 1'b1;
    bus.BrPC  = 32'h200;
    flushes("fault_oor", 1'b1, 1'b1);
    push("fault_oor_fault", SEL_FLT, 32'h1);
    push("fault_oor_pc", SEL_PC, 32'h0);
    push("fault_oor_cnt", SEL_CNT, 32'h0);
    tick();
    idle_inputs();
    reset = 1'b0;
    #1;
    push("fault_oor_rst", SEL_FLT, 32'h0);
    drain();
    @(negedge clk);
    reset = 1'b1;

    // Back-to-back legal redirects saturate the counter.
    bus.PcSel = 1'b1;
    bus.BrPC  = 32'h40;
    for (int i = 0; i < 65533; i++) @(posedge clk);
    push("sat_fffe", SEL_CNT, 32'hFFFE);
    tick();
    push("sat_ffff", SEL_CNT, 32'hFFFF);
    tick();
    for (int i = 0; i < 4; i++) @(posedge clk);
    push("sat_hold", SEL_CNT, 32'hFFFF);
    push("sat_pc", SEL_PC, 32'h40);
    tick();

    // Asynchronous reset in the middle of a redirect stream.
    reset = 1'b0;
    push("midrst_cnt", SEL_CNT, 32'h0);
    push("midrst_pc", SEL_PC, 32'h0);
    push("midrst_fv", SEL_FV, 32'h0);
    flushes("midrst", 1'b0, 1'b0);
    drain();
    idle_inputs();
    @(negedge clk);
    reset = 1'b1;
    push("post_rst_pc", SEL_PC, 32'h4);
    push("post_rst_fv", SEL_FV, 32'h1);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
